mem_request_initiator: RTL and testbench

- Load/store initiator that sits between the execute stage and the data-memory responder (RAM plus memory-mapped IO).
- Decodes a RISC-V load/store funct3 and issues a single sized request on the data-memory request interface.
- Waits for completion or an exception, sign- or zero-extends load data, and returns the result over a ready/valid response port.
- One outstanding transaction at a time.

---
 rtl/mem_request_initiator.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mem_request_initiator.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_initiator.sv
// ============================================================================
// Module   : mem_request_initiator
// Brief    : Load/store initiator. Decodes RISC-V load/store funct3, issues one
//            sized request to the data-memory responder, extends load data and
//            returns the result on a ready/valid response port.
//            Optional macro MEM_TIMEOUT_EN adds an ISSUE-state watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`endif
`ifndef EXCEP_OK
`define EXCEP_OK 4'd0
`endif
`ifndef EXCEP_INVALID_MEM_READ
`define EXCEP_INVALID_MEM_READ 4'd1
`endif
`ifndef EXCEP_INVALID_MEM_WRITE
`define EXCEP_INVALID_MEM_WRITE 4'd2
`endif
`ifndef MEM_WIDTH_BYTE
`define MEM_WIDTH_BYTE 2'b00
`endif
`ifndef MEM_WIDTH_HALF
`define MEM_WIDTH_HALF 2'b01
`endif
`ifndef MEM_WIDTH_WORD
`define MEM_WIDTH_WORD 2'b10
`endif

module mem_request_initiator #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      reqValid_In,
    output logic                      reqReady_Out,
    input  logic                      reqIsLoad_In,
    input  logic [2:0]                reqFunct3_In,
    input  logic [31:0]               reqAddr_In,
    input  logic [31:0]               reqStoreData_In,
    input  logic [4:0]                reqRd_In,
    output logic [31:0]               memAddr_Out,
    output logic [31:0]               memData_Out,
    output logic [1:0]                memDataWidth_Out,
    output logic                      memIsRead_Out,
    output logic                      memValid_Out,
    input  logic [`EXCEPTION_LEN-1:0] memException_In,
    input  logic [31:0]               memData_In,
    input  logic                      memOperationOK_In,
    output logic                      respValid_Out,
    input  logic                      respReady_In,
    output logic [31:0]               respData_Out,
    output logic [4:0]                respRd_Out,
    output logic [`EXCEPTION_LEN-1:0] respException_Out,
    output logic [31:0]               respFaultAddr_Out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // The watchdog compare must be representable in the counter width.
    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TIMEOUT_W)) begin : g_bad_timeout_cfg
            $error("mem_request_initiator: TIMEOUT_CYCLES must be in [1, 2**TIMEOUT_W)");
        end
    endgenerate

    state_t                    r_state_q,          w_state_d;
    logic                      r_req_ready_q,      w_req_ready_d;
    logic [2:0]                r_funct3_q,         w_funct3_d;
    logic [31:0]               r_mem_addr_q,       w_mem_addr_d;
    logic [31:0]               r_mem_data_q,       w_mem_data_d;
    logic [1:0]                r_mem_width_q,      w_mem_width_d;
    logic                      r_mem_is_read_q,    w_mem_is_read_d;
    logic                      r_mem_valid_q,      w_mem_valid_d;
    logic                      r_resp_valid_q,     w_resp_valid_d;
    logic [31:0]               r_resp_data_q,      w_resp_data_d;
    logic [4:0]                r_resp_rd_q,        w_resp_rd_d;
    logic [`EXCEPTION_LEN-1:0] r_resp_exc_q,       w_resp_exc_d;
    logic [31:0]               r_resp_fault_q,     w_resp_fault_d;
    logic                      w_tmo_hit;

`ifdef MEM_TIMEOUT_EN
    logic [TIMEOUT_W-1:0]      r_tmo_cnt_q,        w_tmo_cnt_d;
    assign w_tmo_hit = (r_tmo_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    function automatic logic f_is_legal(input logic is_load, input logic [2:0] f3);
        if (is_load)
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                   (f3 == 3'b100) || (f3 == 3'b101);
        else
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    endfunction

    function automatic logic [1:0] f_width(input logic [1:0] size);
        case (size)
            2'b00:   return `MEM_WIDTH_BYTE;
            2'b01:   return `MEM_WIDTH_HALF;
            default: return `MEM_WIDTH_WORD;
        endcase
    endfunction

    // funct3[2] selects zero-extension (LBU/LHU).
    function automatic logic [31:0] f_extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'b0, d[7:0]}  : {{24{d[7]}},  d[7:0]};
            2'b01:   return f3[2] ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    always_comb begin
        w_state_d       = r_state_q;
        w_req_ready_d   = r_req_ready_q;
        w_funct3_d      = r_funct3_q;
        w_mem_addr_d    = r_mem_addr_q;
        w_mem_data_d    = r_mem_data_q;
        w_mem_width_d   = r_mem_width_q;
        w_mem_is_read_d = r_mem_is_read_q;
        w_mem_valid_d   = r_mem_valid_q;
        w_resp_valid_d  = r_resp_valid_q;
        w_resp_data_d   = r_resp_data_q;
        w_resp_rd_d     = r_resp_rd_q;
        w_resp_exc_d    = r_resp_exc_q;
        w_resp_fault_d  = r_resp_fault_q;
`ifdef MEM_TIMEOUT_EN
        w_tmo_cnt_d     = r_tmo_cnt_q;
`endif

        case (r_state_q)
            S_IDLE: begin
                if (reqValid_In && r_req_ready_q) begin
                    w_req_ready_d = 1'b0;
                    w_funct3_d    = reqFunct3_In;
                    w_resp_rd_d   = reqRd_In;
                    if (f_is_legal(reqIsLoad_In, reqFunct3_In)) begin
                        w_state_d       = S_ISSUE;
                        w_mem_addr_d    = reqAddr_In;
                        w_mem_data_d    = reqIsLoad_In ? 32'd0 : reqStoreData_In;
                        w_mem_width_d   = f_width(reqFunct3_In[1:0]);
                        w_mem_is_read_d = reqIsLoad_In;
                        w_mem_valid_d   = 1'b1;
`ifdef MEM_TIMEOUT_EN
                        w_tmo_cnt_d     = '0;
`endif
                    end else begin
                        // Illegal encodings never reach the responder.
                        w_state_d      = S_RESP;
                        w_resp_valid_d = 1'b1;
                        w_resp_data_d  = 32'd0;
                        w_resp_exc_d   = reqIsLoad_In ? `EXCEP_INVALID_MEM_READ
                                                      : `EXCEP_INVALID_MEM_WRITE;
                        w_resp_fault_d = reqAddr_In;
                    end
                end
            end

            S_ISSUE: begin
`ifdef MEM_TIMEOUT_EN
                w_tmo_cnt_d = r_tmo_cnt_q + TIMEOUT_W'(1);
`endif
                if (memException_In != `EXCEP_OK) begin
                    w_state_d      = S_RESP;
                    w_mem_valid_d  = 1'b0;
                    w_resp_valid_d = 1'b1;
                    w_resp_data_d  = 32'd0;
                    w_resp_exc_d   = memException_In;
                    w_resp_fault_d = r_mem_addr_q;
                end else if (memOperationOK_In) begin
                    w_state_d      = S_RESP;
                    w_mem_valid_d  = 1'b0;
                    w_resp_valid_d = 1'b1;
                    w_resp_data_d  = r_mem_is_read_q ? f_extend(r_funct3_q, memData_In) : 32'd0;
                    w_resp_exc_d   = `EXCEP_OK;
                    w_resp_fault_d = 32'd0;
                end else if (w_tmo_hit) begin
                    w_state_d      = S_RESP;
                    w_mem_valid_d  = 1'b0;
                    w_resp_valid_d = 1'b1;
                    w_resp_data_d  = 32'd0;
                    w_resp_exc_d   = r_mem_is_read_q ? `EXCEP_INVALID_MEM_READ
                                                     : `EXCEP_INVALID_MEM_WRITE;
                    w_resp_fault_d = r_mem_addr_q;
                end
            end

            S_RESP: begin
                if (respReady_In) begin
                    w_state_d      = S_IDLE;
                    w_resp_valid_d = 1'b0;
                    w_req_ready_d  = 1'b1;
                end
            end

            default: begin
                w_state_d      = S_IDLE;
                w_req_ready_d  = 1'b1;
                w_mem_valid_d  = 1'b0;
                w_resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q       <= S_IDLE;
            r_req_ready_q   <= 1'b1;
            r_funct3_q      <= 3'd0;
            r_mem_addr_q    <= 32'd0;
            r_mem_data_q    <= 32'd0;
            r_mem_width_q   <= 2'd0;
            r_mem_is_read_q <= 1'b0;
            r_mem_valid_q   <= 1'b0;
            r_resp_valid_q  <= 1'b0;
            r_resp_data_q   <= 32'd0;
            r_resp_rd_q     <= 5'd0;
            r_resp_exc_q    <= `EXCEP_OK;
            r_resp_fault_q  <= 32'd0;
`ifdef MEM_TIMEOUT_EN
            r_tmo_cnt_q     <= '0;
`endif
        end else begin
            r_state_q       <= w_state_d;
            r_req_ready_q   <= w_req_ready_d;
            r_funct3_q      <= w_funct3_d;
            r_mem_addr_q    <= w_mem_addr_d;
            r_mem_data_q    <= w_mem_data_d;
            r_mem_width_q   <= w_mem_width_d;
            r_mem_is_read_q <= w_mem_is_read_d;
            r_mem_valid_q   <= w_mem_valid_d;
            r_resp_valid_q  <= w_resp_valid_d;
            r_resp_data_q   <= w_resp_data_d;
            r_resp_rd_q     <= w_resp_rd_d;
            r_resp_exc_q    <= w_resp_exc_d;
            r_resp_fault_q  <= w_resp_fault_d;
`ifdef MEM_TIMEOUT_EN
            r_tmo_cnt_q     <= w_tmo_cnt_d;
`endif
        end
    end

    assign reqReady_Out      = r_req_ready_q;
    assign memAddr_Out       = r_mem_addr_q;
    assign memData_Out       = r_mem_data_q;
    assign memDataWidth_Out  = r_mem_width_q;
    assign memIsRead_Out     = r_mem_is_read_q;
    assign memValid_Out      = r_mem_valid_q;
    assign respValid_Out     = r_resp_valid_q;
    assign respData_Out      = r_resp_data_q;
    assign respRd_Out        = r_resp_rd_q;
    assign respException_Out = r_resp_exc_q;
    assign respFaultAddr_Out = r_resp_fault_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_request_initiator.sv
// ============================================================================
// Module   : tb_mem_request_initiator
// Brief    : Directed scoreboard bench for mem_request_initiator; the driver
//            pushes expected responses, a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`endif
`ifndef EXCEP_OK
`define EXCEP_OK 4'd0
`endif
`ifndef EXCEP_INVALID_MEM_READ
`define EXCEP_INVALID_MEM_READ 4'd1
`endif
`ifndef EXCEP_INVALID_MEM_WRITE
`define EXCEP_INVALID_MEM_WRITE 4'd2
`endif
`ifndef MEM_WIDTH_BYTE
`define MEM_WIDTH_BYTE 2'b00
`endif
`ifndef MEM_WIDTH_HALF
`define MEM_WIDTH_HALF 2'b01
`endif
`ifndef MEM_WIDTH_WORD
`define MEM_WIDTH_WORD 2'b10
`endif

module tb_mem_request_initiator;

    localparam int C_TMO = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      reqValid_In;
    logic                      reqReady_Out;
    logic                      reqIsLoad_In;
    logic [2:0]                reqFunct3_In;
    logic [31:0]               reqAddr_In;
    logic [31:0]               reqStoreData_In;
    logic [4:0]                reqRd_In;
    logic [31:0]               memAddr_Out;
    logic [31:0]               memData_Out;
    logic [1:0]                memDataWidth_Out;
    logic                      memIsRead_Out;
    logic                      memValid_Out;
    logic [`EXCEPTION_LEN-1:0] memException_In;
    logic [31:0]               memData_In;
    logic                      memOperationOK_In;
    logic                      respValid_Out;
    logic                      respReady_In;
    logic [31:0]               respData_Out;
    logic [4:0]                respRd_Out;
    logic [`EXCEPTION_LEN-1:0] respException_Out;
    logic [31:0]               respFaultAddr_Out;

    mem_request_initiator #(
        .TIMEOUT_CYCLES (C_TMO),
        .TIMEOUT_W      (8)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .reqValid_In       (reqValid_In),
        .reqReady_Out      (reqReady_Out),
        .reqIsLoad_In      (reqIsLoad_In),
        .reqFunct3_In      (reqFunct3_In),
        .reqAddr_In        (reqAddr_In),
        .reqStoreData_In   (reqStoreData_In),
        .reqRd_In          (reqRd_In),
        .memAddr_Out       (memAddr_Out),
        .memData_Out       (memData_Out),
        .memDataWidth_Out  (memDataWidth_Out),
        .memIsRead_Out     (memIsRead_Out),
        .memValid_Out      (memValid_Out),
        .memException_In   (memException_In),
        .memData_In        (memData_In),
        .memOperationOK_In (memOperationOK_In),
        .respValid_Out     (respValid_Out),
        .respReady_In      (respReady_In),
        .respData_Out      (respData_Out),
        .respRd_Out        (respRd_Out),
        .respException_Out (respException_Out),
        .respFaultAddr_Out (respFaultAddr_Out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [3:0]  exc;
        logic [31:0] fault;
        int          rise;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: checks rise latency on the first valid cycle, full response on handshake.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (respValid_Out && !prev_valid) begin
                if (sb.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
                else                chk("resp_latency", cyc, sb[0].rise);
            end
            if (respValid_Out && respReady_In && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_data",  respData_Out,      e.data);
                chk("resp_rd",    32'(respRd_Out),   32'(e.rd));
                chk("resp_exc",   32'(respException_Out), 32'(e.exc));
                chk("resp_fault", respFaultAddr_Out, e.fault);
            end
            prev_valid <= respValid_Out;
        end
    end

    // d < 0: responder never answers (watchdog case).
    task automatic do_txn(input bit is_load, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd, input bit legal,
                          input int d, input logic [31:0] rdata, input logic [3:0] mexc,
                          input bit mok, input logic [31:0] exp_data, input logic [3:0] exp_exc,
                          input logic [31:0] exp_fault, input int hold, input logic [1:0] exp_w);
        int   a;
        int   n;
        exp_t e;
        n = 0;
        while (!reqReady_Out && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_idle", 32'(reqReady_Out), 32'd1);
        reqIsLoad_In    = is_load;
        reqFunct3_In    = f3;
        reqAddr_In      = addr;
        reqStoreData_In = sdata;
        reqRd_In        = rd;
        reqValid_In     = 1'b1;
        @(posedge clk); #1;
        a = cyc;
        reqValid_In = 1'b0;
        e.data  = exp_data;
        e.rd    = rd;
        e.exc   = exp_exc;
        e.fault = exp_fault;
        e.rise  = !legal ? a : (d < 0 ? a + C_TMO : a + d + 1);
        sb.push_back(e);

        if (legal) begin
            chk("mem_valid", 32'(memValid_Out), 32'd1);
            chk("mem_addr",  memAddr_Out, addr);
            chk("mem_width", 32'(memDataWidth_Out), 32'(exp_w));
            chk("mem_read",  32'(memIsRead_Out), 32'(is_load));
            if (!is_load) chk("mem_data", memData_Out, sdata);
            for (int i = 0; i < d; i++) begin
                @(posedge clk); #1;
                chk("mem_valid_hold", 32'(memValid_Out), 32'd1);
                chk("mem_addr_hold",  memAddr_Out, addr);
                chk("req_ready_busy", 32'(reqReady_Out), 32'd0);
            end
            if (d >= 0) begin
                memData_In        = rdata;
                memException_In   = mexc;
                memOperationOK_In = mok;
                @(posedge clk); #1;
                memException_In   = `EXCEP_OK;
                memOperationOK_In = 1'b0;
                chk("mem_valid_drop", 32'(memValid_Out), 32'd0);
            end
        end else begin
            chk("illegal_no_mem", 32'(memValid_Out), 32'd0);
        end

        n = 0;
        while (!respValid_Out && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("resp_seen", 32'(respValid_Out), 32'd1);
        for (int h = 0; h < hold; h++) begin
            chk("hold_req_ready", 32'(reqReady_Out), 32'd0);
            chk("hold_mem_valid", 32'(memValid_Out), 32'd0);
            chk("hold_resp_data", respData_Out, exp_data);
            chk("hold_resp_exc",  32'(respException_Out), 32'(exp_exc));
            @(posedge clk); #1;
            chk("hold_resp_valid", 32'(respValid_Out), 32'd1);
        end
        respReady_In = 1'b1;
        @(posedge clk); #1;
        respReady_In = 1'b0;
        chk("resp_valid_fall", 32'(respValid_Out), 32'd0);
        chk("req_ready_back",  32'(reqReady_Out), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        reqValid_In = 0; reqIsLoad_In = 0; reqFunct3_In = 0; reqAddr_In = 0;
        reqStoreData_In = 0; reqRd_In = 0; memException_In = `EXCEP_OK;
        memData_In = 0; memOperationOK_In = 0; respReady_In = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_valid",  32'(memValid_Out), 32'd0);
        chk("rst_resp_valid", 32'(respValid_Out), 32'd0);
        chk("rst_resp_exc",   32'(respException_Out), 32'(`EXCEP_OK));
        chk("rst_mem_addr",   memAddr_Out, 32'd0);
        chk("rst_resp_data",  respData_Out, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_req_ready",  32'(reqReady_Out), 32'd1);

        //     ld f3      addr          sdata         rd legal d  rdata         mexc                      ok exp_data      exp_exc                   exp_fault     hold width
        do_txn(1, 3'b000, 32'h40000003, 32'h0,        5, 1,   1, 32'h000000F0, `EXCEP_OK,               1, 32'hFFFFFFF0, `EXCEP_OK,               32'h0,        0, `MEM_WIDTH_BYTE);
        do_txn(1, 3'b101, 32'h60000002, 32'h0,        7, 1,   0, 32'h0000ABCD, `EXCEP_OK,               1, 32'h0000ABCD, `EXCEP_OK,               32'h0,        0, `MEM_WIDTH_HALF);
        do_txn(0, 3'b010, 32'h40000010, 32'hDEADBEEF, 0, 1,   2, 32'h11111111, `EXCEP_OK,               1, 32'h0,        `EXCEP_OK,               32'h0,        3, `MEM_WIDTH_WORD);
        do_txn(1, 3'b010, 32'h40000002, 32'h0,        9, 1,   0, 32'h12345678, `EXCEP_INVALID_MEM_READ, 1, 32'h0,        `EXCEP_INVALID_MEM_READ, 32'h40000002, 0, `MEM_WIDTH_WORD);
        do_txn(0, 3'b100, 32'h40000020, 32'h55,       3, 0,   0, 32'h0,        `EXCEP_OK,               0, 32'h0,        `EXCEP_INVALID_MEM_WRITE,32'h40000020, 1, `MEM_WIDTH_WORD);
        do_txn(1, 3'b001, 32'h40000004, 32'h0,        11,1,   0, 32'h12348001, `EXCEP_OK,               1, 32'hFFFF8001, `EXCEP_OK,               32'h0,        0, `MEM_WIDTH_HALF);
        do_txn(1, 3'b100, 32'h40000005, 32'h0,        12,1,   1, 32'h000000F0, `EXCEP_OK,               1, 32'h000000F0, `EXCEP_OK,               32'h0,        1, `MEM_WIDTH_BYTE);
        do_txn(1, 3'b010, 32'h40000008, 32'h0,        13,1,   4, 32'h89ABCDEF, `EXCEP_OK,               1, 32'h89ABCDEF, `EXCEP_OK,               32'h0,        0, `MEM_WIDTH_WORD);
        do_txn(1, 3'b011, 32'h40000030, 32'h0,        14,0,   0, 32'h0,        `EXCEP_OK,               0, 32'h0,        `EXCEP_INVALID_MEM_READ, 32'h40000030, 0, `MEM_WIDTH_WORD);
        do_txn(0, 3'b000, 32'h40000041, 32'hA5,       15,1,   1, 32'h0,        4'd7,                    0, 32'h0,        4'd7,                    32'h40000041, 0, `MEM_WIDTH_BYTE);

        // Reset in the middle of ISSUE: memValid must drop without a clock edge.
        reqIsLoad_In = 1; reqFunct3_In = 3'b010; reqAddr_In = 32'h40000044; reqRd_In = 5'd20;
        reqValid_In = 1'b1;
        @(posedge clk); #1;
        reqValid_In = 1'b0;
        chk("pre_rst_mem_valid", 32'(memValid_Out), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_mem_valid", 32'(memValid_Out), 32'd0);
        chk("async_rst_req_ready", 32'(reqReady_Out), 32'd1);
        chk("async_rst_resp_valid", 32'(respValid_Out), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_txn(1, 3'b010, 32'h40000000, 32'h0, 21, 1, 0, 32'hCAFEF00D, `EXCEP_OK, 1,
               32'hCAFEF00D, `EXCEP_OK, 32'h0, 0, `MEM_WIDTH_WORD);

`ifdef MEM_TIMEOUT_EN
        do_txn(1, 3'b010, 32'h40000050, 32'h0, 22, 1, -1, 32'h0, `EXCEP_OK, 0,
               32'h0, `EXCEP_INVALID_MEM_READ, 32'h40000050, 0, `MEM_WIDTH_WORD);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
